// File: rtl/fetch_ctrl_pkg.sv
// Shared encodings for the fetch sequencing controller: PC mux select values,
// controller states and the bundle of fetch-stage control strobes.
package fetch_ctrl_pkg;

   localparam logic [1:0] PC_INCR   = 2'b00;
   localparam logic [1:0] PC_BRANCH = 2'b01;
   localparam logic [1:0] PC_REG    = 2'b10;
   localparam logic [1:0] PC_HOLD   = 2'b11;

   typedef enum logic [1:0] {
      FC_BOOT  = 2'd0,
      FC_RUN   = 2'd1,
      FC_STALL = 2'd2,
      FC_HALT  = 2'd3
   } fc_state_e;

   typedef struct packed {
      logic [1:0] pc_src;
      logic       ifid_we;
      logic       ifid_flush;
      logic       idex_flush;
   } fetch_ctl_t;

   // PC frozen with both pipeline registers flushed: used in boot, halt and reset.
   function automatic fetch_ctl_t hold_ctl();
      return '{PC_HOLD, 1'b0, 1'b1, 1'b1};
   endfunction

endpackage

// File: rtl/fetch_ctrl_sat_counter.sv
// Saturating up-counter used for the debug performance counters; sticks at all-ones.
module sat_counter #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         inc,
   output logic [W-1:0] q
);

   logic [W-1:0] q_q;
   logic [W-1:0] q_d;

   always_comb begin
      q_d = q_q;
      if (inc && (q_q != '1)) q_d = q_q + W'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) q_q <= '0;
      else     q_q <= q_d;
   end

   assign q = q_q;

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch-stage sequencing: boot hold, load-use stalls, branch redirects and halt,
// with redirect/stall performance counters and a sticky stall-timeout flag.
//
// state    | meaning
// FC_BOOT  | PC held after reset release for BOOT_CYCLES cycles
// FC_RUN   | normal fetch; redirect > halt > stall > advance
// FC_STALL | previous cycle was a load-use stall; same arbitration as RUN
// FC_HALT  | fetch frozen until reset
module fetch_ctrl
   import fetch_ctrl_pkg::*;
#(
   parameter int BOOT_CYCLES   = 4,
   parameter int STALL_TIMEOUT = 64,
   parameter int CNT_W         = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             stall_req,
   input  logic             br_taken,
   input  logic             br_reg,
   input  logic             halt_dec,
   output logic [1:0]       PCSrc,
   output logic             ifid_we,
   output logic             ifid_flush,
   output logic             idex_flush,
   output logic             halted,
   output logic             stall_err,
   output logic [CNT_W-1:0] redirect_cnt,
   output logic [CNT_W-1:0] stall_cnt
);

   localparam logic [7:0]  BOOT_LAST = 8'(BOOT_CYCLES - 1);
   localparam logic [15:0] TIMEOUT   = 16'(STALL_TIMEOUT);

   fc_state_e  state_q, state_d;
   logic [7:0] boot_q, boot_d;
   logic [15:0] run_q, run_d;
   logic       err_q, err_d;
   fetch_ctl_t ctl;
   logic       halted_c;
   logic       redirect_inc;
   logic       stall_inc;

   always_comb begin
      state_d      = state_q;
      boot_d       = boot_q;
      run_d        = '0;
      err_d        = err_q;
      ctl          = hold_ctl();
      halted_c     = 1'b0;
      redirect_inc = 1'b0;
      stall_inc    = 1'b0;

      case (state_q)
         FC_BOOT: begin
            if (boot_q == BOOT_LAST) begin
               state_d = FC_RUN;
               boot_d  = '0;
            end else begin
               boot_d = boot_q + 8'd1;
            end
         end
         FC_RUN, FC_STALL: begin
            if (br_reg || br_taken) begin
               // Redirect beats a pending stall: the stalled instruction is wrong-path.
               ctl          = '{(br_reg ? PC_REG : PC_BRANCH), 1'b1, 1'b1, 1'b1};
               redirect_inc = 1'b1;
               state_d      = FC_RUN;
            end else if (halt_dec) begin
               ctl     = hold_ctl();
               state_d = FC_HALT;
            end else if (stall_req) begin
               ctl       = '{PC_HOLD, 1'b0, 1'b0, 1'b1};
               stall_inc = 1'b1;
               run_d     = (run_q == 16'hFFFF) ? run_q : run_q + 16'd1;
               if (run_d >= TIMEOUT) err_d = 1'b1;
               state_d   = FC_STALL;
            end else begin
               ctl     = '{PC_INCR, 1'b1, 1'b0, 1'b0};
               state_d = FC_RUN;
            end
         end
         FC_HALT: halted_c = 1'b1;
         default: state_d = FC_BOOT;
      endcase

      if (rst) begin
         ctl          = hold_ctl();
         halted_c     = 1'b0;
         redirect_inc = 1'b0;
         stall_inc    = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= FC_BOOT;
         boot_q  <= '0;
         run_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         boot_q  <= boot_d;
         run_q   <= run_d;
         err_q   <= err_d;
      end
   end

   sat_counter #(.W(CNT_W)) u_redirect_cnt (
      .clk (clk),
      .rst (rst),
      .inc (redirect_inc),
      .q   (redirect_cnt)
   );

   sat_counter #(.W(CNT_W)) u_stall_cnt (
      .clk (clk),
      .rst (rst),
      .inc (stall_inc),
      .q   (stall_cnt)
   );

   assign PCSrc      = ctl.pc_src;
   assign ifid_we    = ctl.ifid_we;
   assign ifid_flush = ctl.ifid_flush;
   assign idex_flush = ctl.idex_flush;
   assign halted     = halted_c;
   assign stall_err  = err_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed scenarios followed by random traffic, every cycle
// compared against a cycle-level behavioural model of the controller.
module tb_fetch_ctrl;

   localparam int BOOT = 4;
   localparam int TMO  = 8;
   localparam int CW   = 4;
   localparam int CMAX = (1 << CW) - 1;

   logic          clk = 1'b0;
   logic          rst, stall_req, br_taken, br_reg, halt_dec;
   logic [1:0]    PCSrc;
   logic          ifid_we, ifid_flush, idex_flush, halted, stall_err;
   logic [CW-1:0] redirect_cnt, stall_cnt;

   fetch_ctrl #(.BOOT_CYCLES(BOOT), .STALL_TIMEOUT(TMO), .CNT_W(CW)) dut (
      .clk          (clk),
      .rst          (rst),
      .stall_req    (stall_req),
      .br_taken     (br_taken),
      .br_reg       (br_reg),
      .halt_dec     (halt_dec),
      .PCSrc        (PCSrc),
      .ifid_we      (ifid_we),
      .ifid_flush   (ifid_flush),
      .idex_flush   (idex_flush),
      .halted       (halted),
      .stall_err    (stall_err),
      .redirect_cnt (redirect_cnt),
      .stall_cnt    (stall_cnt)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   // model: boot cycles still to serve, halted flag, current stall run, counters
   int m_boot_left;
   bit m_halt;
   int m_run;
   bit m_err;
   int m_rcnt;
   int m_scnt;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic void m_reset();
      m_boot_left = BOOT;
      m_halt      = 1'b0;
      m_run       = 0;
      m_err       = 1'b0;
      m_rcnt      = 0;
      m_scnt      = 0;
   endfunction

   // One clock: apply inputs, check against the model mid-cycle, advance model at the edge.
   task automatic cyc(input bit r, input bit s, input bit bt, input bit br, input bit hd);
      logic [1:0] e_pc;
      bit e_we, e_iff, e_idf, e_h, chk_iff;
      rst = r; stall_req = s; br_taken = bt; br_reg = br; halt_dec = hd;
      @(negedge clk);
      check("stall_err", 32'(stall_err), 32'(m_err));
      check("redirect_cnt", 32'(redirect_cnt), 32'(m_rcnt));
      check("stall_cnt", 32'(stall_cnt), 32'(m_scnt));
      chk_iff = 1'b1;
      e_pc = 2'b11; e_we = 1'b0; e_iff = 1'b1; e_idf = 1'b1; e_h = 1'b0;
      if (r) begin
         m_reset();
      end else if (m_boot_left > 0) begin
         m_boot_left--;
         m_run = 0;
      end else if (m_halt) begin
         e_h = 1'b1;
      end else if (bt || br) begin
         e_pc = br ? 2'b10 : 2'b01; e_we = 1'b1;
         if (m_rcnt < CMAX) m_rcnt++;
         m_run = 0;
      end else if (hd) begin
         chk_iff = 1'b0;
         m_halt  = 1'b1;
         m_run   = 0;
      end else if (s) begin
         e_iff = 1'b0;
         if (m_scnt < CMAX) m_scnt++;
         m_run++;
         if (m_run >= TMO) m_err = 1'b1;
      end else begin
         e_pc = 2'b00; e_we = 1'b1; e_iff = 1'b0; e_idf = 1'b0;
         m_run = 0;
      end
      check("PCSrc", 32'(PCSrc), 32'(e_pc));
      check("ifid_we", 32'(ifid_we), 32'(e_we));
      if (chk_iff) check("ifid_flush", 32'(ifid_flush), 32'(e_iff));
      check("idex_flush", 32'(idex_flush), 32'(e_idf));
      check("halted", 32'(halted), 32'(e_h));
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input int n);
      for (int i = 0; i < n; i++) cyc(1, 0, 0, 0, 0);
   endtask

   // Boot window; a redirect on the last boot cycle must be ignored.
   task automatic do_boot();
      for (int i = 0; i < BOOT - 1; i++) cyc(0, 1, 0, 0, 1);
      cyc(0, 0, 1, 1, 0);
   endtask

   initial begin
      rst = 1'b1; stall_req = 1'b0; br_taken = 1'b0; br_reg = 1'b0; halt_dec = 1'b0;
      @(posedge clk);
      #1;
      m_reset();

      do_reset(3);
      do_boot();
      cyc(0, 0, 0, 0, 0);
      check("boot_no_redirect", 32'(redirect_cnt), 32'd0);

      cyc(0, 1, 0, 0, 0);
      cyc(0, 1, 0, 0, 0);
      cyc(0, 0, 0, 0, 0);
      check("stall_cnt_two", 32'(stall_cnt), 32'd2);

      cyc(0, 1, 1, 0, 0);
      check("redir_over_stall_rc", 32'(redirect_cnt), 32'd1);
      check("redir_over_stall_sc", 32'(stall_cnt), 32'd2);
      cyc(0, 0, 1, 1, 0);
      cyc(0, 0, 1, 0, 1);
      check("halt_lost_to_redirect", 32'(halted), 32'd0);

      cyc(0, 0, 0, 0, 1);
      cyc(0, 0, 1, 0, 0);
      cyc(0, 1, 0, 1, 0);
      check("halt_sticky", 32'(halted), 32'd1);
      check("halt_pc_hold", 32'(PCSrc), 32'd3);

      do_reset(1);
      check("reset_halted", 32'(halted), 32'd0);
      check("reset_rcnt", 32'(redirect_cnt), 32'd0);
      do_boot();

      for (int i = 0; i < TMO - 1; i++) cyc(0, 1, 0, 0, 0);
      cyc(0, 0, 0, 0, 0);
      check("timeout_7", 32'(stall_err), 32'd0);
      for (int i = 0; i < TMO; i++) cyc(0, 1, 0, 0, 0);
      check("timeout_8", 32'(stall_err), 32'd1);
      cyc(0, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0);
      check("timeout_sticky", 32'(stall_err), 32'd1);

      for (int i = 0; i < 20; i++) cyc(0, 0, 1, 0, 0);
      check("redirect_sat", 32'(redirect_cnt), 32'(CMAX));

      cyc(0, 1, 0, 0, 0);
      cyc(0, 1, 0, 0, 0);
      do_reset(1);
      check("midstall_rcnt", 32'(redirect_cnt), 32'd0);
      check("midstall_scnt", 32'(stall_cnt), 32'd0);
      check("midstall_err", 32'(stall_err), 32'd0);

      for (int i = 0; i < 3000; i++) begin
         cyc(($urandom_range(63) == 0),
             ($urandom_range(99) < 45),
             ($urandom_range(99) < 10),
             ($urandom_range(99) < 5),
             ($urandom_range(99) < 2));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
